// File: rtl/ssd_key_display_if.sv
// ---------------------------------------------------------------------------
// ssd_key_display_if
//   Bundles the keypad-side and display-side signals of ssd_key_display.
//
//   Signals:
//     key_code  [3:0]             hex code from the keypad decoder
//     key_valid                   high while the decoder reports a key pressed
//     clear                       single-cycle synchronous clear of the buffer
//     digits    [4*NUM_DIGITS-1:0] digit buffer, nibble 0 is the newest digit
//     new_key                     one-cycle pulse when a digit is accepted
//     an        [NUM_DIGITS-1:0]  anode enables, active-low
//     seg       [6:0]             cathodes {g,f,e,d,c,b,a}, active-low
//
//   Modports:
//     master : keypad / host side (drives key inputs and clear)
//     slave  : the display controller
// ---------------------------------------------------------------------------
interface ssd_key_display_if #(
    parameter int NUM_DIGITS = 4
);
    logic [3:0]              key_code;
    logic                    key_valid;
    logic                    clear;
    logic [4*NUM_DIGITS-1:0] digits;
    logic                    new_key;
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;

    modport master (
        output key_code, key_valid, clear,
        input  digits, new_key, an, seg
    );

    modport slave (
        input  key_code, key_valid, clear,
        output digits, new_key, an, seg
    );
endinterface

// File: rtl/ssd_key_display.sv
// ---------------------------------------------------------------------------
// ssd_key_display
//   Debounces keypad presses, shifts each newly pressed hex digit into a
//   NUM_DIGITS-deep buffer from the right (calculator-style entry), and
//   time-multiplexes the buffer onto a common-anode seven-segment display.
//
//   Ports:
//     clk  : system clock
//     rst  : asynchronous, active-high reset
//     bus  : ssd_key_display_if.slave (key_code, key_valid, clear in;
//            digits, new_key, an, seg out)
//
//   Parameters:
//     DEBOUNCE_CYCLES : stable cycles required to accept a press/release (>=2)
//     REFRESH_CYCLES  : cycles each digit is lit before advancing (>=2)
//     NUM_DIGITS      : display digits / buffer nibbles (>=2)
//
//   Optional feature (compile-time macro LEADING_ZERO_BLANK_EN):
//     when defined, digit i>0 is blanked while nibbles i..NUM_DIGITS-1 are
//     all zero; the anode is still scanned. Digit 0 is always shown.
// ---------------------------------------------------------------------------
module ssd_key_display #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REFRESH_CYCLES  = 100000,
    parameter int NUM_DIGITS      = 4
) (
    input logic              clk,
    input logic              rst,
    ssd_key_display_if.slave bus
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int RCNT_W = $clog2(REFRESH_CYCLES);
    localparam int IDX_W  = $clog2(NUM_DIGITS);

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REFRESH_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        RELEASE_CHK
    } state_t;

    // Input stage
    logic       r_kv_q;
    logic [3:0] r_kc_q;

    // Debounce FSM
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic [3:0]       r_code,  w_code_nxt;
    logic             w_accept;

    // Digit buffer
    logic [4*NUM_DIGITS-1:0] r_digits;
    logic                    r_new_key;

    // Display scan
    logic [RCNT_W-1:0]     r_rcnt;
    logic [IDX_W-1:0]      r_idx;
    logic [3:0]            w_nibble;
    logic                  w_blank;
    logic [NUM_DIGITS-1:0] r_an;
    logic [6:0]            r_seg;

    function automatic logic [6:0] seg_font(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'b1000000;
            4'h1: pat = 7'b1111001;
            4'h2: pat = 7'b0100100;
            4'h3: pat = 7'b0110000;
            4'h4: pat = 7'b0011001;
            4'h5: pat = 7'b0010010;
            4'h6: pat = 7'b0000010;
            4'h7: pat = 7'b1111000;
            4'h8: pat = 7'b0000000;
            4'h9: pat = 7'b0010000;
            4'hA: pat = 7'b0001000;
            4'hB: pat = 7'b0000011;
            4'hC: pat = 7'b1000110;
            4'hD: pat = 7'b0100001;
            4'hE: pat = 7'b0000110;
            default: pat = 7'b0001110;
        endcase
        return pat;
    endfunction

    // The keypad decoder's outputs are registered once before any use.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_kv_q <= 1'b0;
            r_kc_q <= 4'h0;
        end else begin
            r_kv_q <= bus.key_valid;
            r_kc_q <= bus.key_code;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_code  <= 4'h0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_code  <= w_code_nxt;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_code_nxt  = r_code;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_kv_q) begin
                    w_code_nxt  = r_kc_q;
                    w_cnt_nxt   = '0;
                    w_state_nxt = PRESS_CHK;
                end
            end
            PRESS_CHK: begin
                // A drop-out or a code change restarts the qualification.
                if (!r_kv_q || (r_kc_q != r_code)) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_accept    = 1'b1;
                    w_state_nxt = HELD;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            HELD: begin
                // No auto-repeat; code changes while held are ignored.
                if (!r_kv_q) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = RELEASE_CHK;
                end
            end
            RELEASE_CHK: begin
                if (r_kv_q) begin
                    w_state_nxt = HELD;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Clear has priority over a simultaneous accept and suppresses its pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digits  <= '0;
            r_new_key <= 1'b0;
        end else begin
            r_new_key <= w_accept & ~bus.clear;
            if (bus.clear) begin
                r_digits <= '0;
            end else if (w_accept) begin
                r_digits <= {r_digits[4*NUM_DIGITS-5:0], r_code};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rcnt <= '0;
            r_idx  <= '0;
        end else if (r_rcnt == RCNT_LAST) begin
            r_rcnt <= '0;
            r_idx  <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_rcnt <= r_rcnt + 1'b1;
        end
    end

    always_comb begin
        w_nibble = 4'h0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == IDX_W'(i)) w_nibble = r_digits[4*i +: 4];
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Walk from the most significant nibble down; a digit is blank while it
    // and everything above it are zero. Digit 0 is never considered.
    always_comb begin
        logic v_upper_zero;
        v_upper_zero = 1'b1;
        w_blank      = 1'b0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            v_upper_zero = v_upper_zero && (r_digits[4*i +: 4] == 4'h0);
            if (r_idx == IDX_W'(i)) w_blank = v_upper_zero;
        end
    end
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an  <= '1;
            r_seg <= 7'b1111111;
        end else begin
            r_an  <= ~(NUM_DIGITS'(1) << r_idx);
            r_seg <= w_blank ? 7'b1111111 : seg_font(w_nibble);
        end
    end

    assign bus.digits  = r_digits;
    assign bus.new_key = r_new_key;
    assign bus.an      = r_an;
    assign bus.seg     = r_seg;

endmodule

// File: tb/tb_ssd_key_display.sv
// ---------------------------------------------------------------------------
// tb_ssd_key_display
//   Self-checking bench for ssd_key_display (DEBOUNCE_CYCLES=4,
//   REFRESH_CYCLES=3, NUM_DIGITS=4). A reference model tracks run lengths of
//   stable key samples and the scan position; outputs are compared on every
//   falling edge, plus directed scenario checks.
// ---------------------------------------------------------------------------
module tb_ssd_key_display;

    localparam int D = 4;
    localparam int R = 3;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;

    ssd_key_display_if #(.NUM_DIGITS(N)) bus ();

    ssd_key_display #(
        .DEBOUNCE_CYCLES(D),
        .REFRESH_CYCLES (R),
        .NUM_DIGITS     (N)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [6:0] font_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic        m_kvq = 1'b0;
    logic [3:0]  m_kcq = 4'h0;
    bit          m_held = 1'b0;      // a press was accepted and not yet released
    int          m_run = 0;          // consecutive qualifying samples so far
    logic [3:0]  m_code = 4'h0;
    logic [15:0] m_digits = 16'h0;
    int          m_idx = 0;
    int          m_rcnt = 0;
    logic [3:0]  exp_an = 4'hF;
    logic [6:0]  exp_seg = 7'h7F;
    logic        exp_new = 1'b0;

    // A press is taken once D+1 consecutive registered samples show the same
    // code held; a release needs D+1 consecutive idle samples.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_kvq = 0; m_kcq = 0; m_held = 0; m_run = 0; m_code = 0;
            m_digits = 0; m_idx = 0; m_rcnt = 0;
            exp_an = 4'hF; exp_seg = 7'h7F; exp_new = 0;
        end else begin
            bit accept;
            bit blank;
            accept = 0;
            exp_an = ~(4'(1) << m_idx);
`ifdef LEADING_ZERO_BLANK_EN
            blank = (m_idx > 0) && ((m_digits >> (4 * m_idx)) == 16'h0);
`else
            blank = 0;
`endif
            exp_seg = blank ? 7'h7F : font_tab[(m_digits >> (4 * m_idx)) & 16'hF];
            if (!m_held) begin
                if (m_kvq && (m_run == 0 || m_kcq == m_code)) begin
                    if (m_run == 0) m_code = m_kcq;
                    m_run++;
                    if (m_run == D + 1) begin
                        accept = 1; m_held = 1; m_run = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end else begin
                if (!m_kvq) begin
                    m_run++;
                    if (m_run == D + 1) begin
                        m_held = 0; m_run = 0;
                    end
                end else begin
                    m_run = 0;
                end
            end
            exp_new = accept && !bus.clear;
            if (bus.clear) m_digits = 16'h0;
            else if (accept) m_digits = {m_digits[11:0], m_code};
            if (m_rcnt == R - 1) begin
                m_rcnt = 0;
                m_idx = (m_idx + 1) % N;
            end else begin
                m_rcnt++;
            end
            m_kvq = bus.key_valid;
            m_kcq = bus.key_code;
        end
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("digits", bus.digits, m_digits);
            check("new_key", bus.new_key, exp_new);
            check("an", bus.an, exp_an);
            check("seg", bus.seg, exp_seg);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic press(input logic [3:0] code, input int hold, input int rel, output int pulses);
        pulses = 0;
        bus.key_code = code;
        bus.key_valid = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (bus.new_key === 1'b1) pulses++;
        end
        bus.key_valid = 1'b0;
        repeat (rel) begin
            @(negedge clk);
            if (bus.new_key === 1'b1) pulses++;
        end
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
    endtask

    // Drives key_valid high and returns the posedge index (0 = first edge
    // that samples it) at which new_key was registered, or -1 if none.
    task automatic press_latency(input logic [3:0] code, output int lat);
        lat = -1;
        bus.key_code = code;
        bus.key_valid = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus.new_key === 1'b1 && lat < 0) lat = k - 1;
        end
    endtask

    initial begin
        int p, tot, lat;
        logic [15:0] snap;
        logic [3:0]  prev_an;
        int          run;
        bit          seen_edge;

        bus.key_code = 4'h0;
        bus.key_valid = 1'b0;
        bus.clear = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_an", bus.an, 4'hF);
        check("rst_seg", bus.seg, 7'h7F);
        check("rst_digits", bus.digits, 16'h0);
        check("rst_new_key", bus.new_key, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("an_one_hot_after_reset", bus.an, 4'b1110);

        // Single press of 5: one pulse, five edges after first sampling edge.
        press_latency(4'h5, lat);
        check("press_latency", lat, 5);
        bus.key_valid = 1'b0;
        repeat (12) @(negedge clk);
        check("digits_after_5", bus.digits, 16'h0005);

        // Bounce on code 9: never stable long enough.
        snap = bus.digits;
        tot = 0;
        bus.key_code = 4'h9;
        for (int i = 0; i < 6; i++) begin
            bus.key_valid = (i % 3 != 2);
            @(negedge clk);
            if (bus.new_key === 1'b1) tot++;
        end
        bus.key_valid = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.new_key === 1'b1) tot++;
        end
        check("bounce_pulses", tot, 0);
        check("bounce_digits", bus.digits, snap);

        // Presses 1,2,3,4,7; code changes to 8 while 4 is held.
        tot = 0;
        press(4'h1, 8, 8, p); tot += p;
        press(4'h2, 8, 8, p); tot += p;
        press(4'h3, 8, 8, p); tot += p;
        bus.key_code = 4'h4;
        bus.key_valid = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (bus.new_key === 1'b1) tot++;
        end
        bus.key_code = 4'h8;
        repeat (8) begin
            @(negedge clk);
            if (bus.new_key === 1'b1) tot++;
        end
        bus.key_valid = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (bus.new_key === 1'b1) tot++;
        end
        press(4'h7, 8, 8, p); tot += p;
        check("five_pulses", tot, 5);
        check("digits_2347", bus.digits, 16'h2347);

        // Scan of 1234.
        do_clear();
        press(4'h1, 8, 8, p);
        press(4'h2, 8, 8, p);
        press(4'h3, 8, 8, p);
        press(4'h4, 8, 8, p);
        check("digits_1234", bus.digits, 16'h1234);
        prev_an = bus.an;
        run = 1;
        seen_edge = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (bus.an == 4'b1110) check("seg_digit0", bus.seg, 7'b0011001);
            if (bus.an == 4'b0111) check("seg_digit3", bus.seg, 7'b1111001);
            if (bus.an === prev_an) begin
                run++;
            end else begin
                if (seen_edge) check("an_hold", run, 3);
                check("an_next", bus.an, {prev_an[2:0], prev_an[3]});
                prev_an = bus.an;
                run = 1;
                seen_edge = 1;
            end
        end

        // Asynchronous reset in the middle of the clock low phase.
        #2 rst = 1'b1;
        #1;
        check("midrst_seg", bus.seg, 7'h7F);
        check("midrst_an", bus.an, 4'hF);
        check("midrst_digits", bus.digits, 16'h0);
        check("midrst_new_key", bus.new_key, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset mid-press: the held key must requalify from scratch.
        bus.key_code = 4'h7;
        bus.key_valid = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus.new_key === 1'b1 && lat < 0) lat = k - 1;
        end
        check("rst_midpress_latency", lat, 5);
        check("rst_midpress_digits", bus.digits, 16'h0007);
        bus.key_valid = 1'b0;
        repeat (8) @(negedge clk);

        // Randomized presses with bounces, code changes and clears.
        for (int it = 0; it < 80; it++) begin
            int hold, rel, chg, clr_at;
            hold   = $urandom_range(1, 10);
            rel    = $urandom_range(1, 10);
            chg    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : -1;
            clr_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 9) : -1;
            bus.key_code = 4'($urandom_range(0, 15));
            bus.key_valid = 1'b1;
            for (int c = 0; c < hold; c++) begin
                if (c == chg) bus.key_code = 4'($urandom_range(0, 15));
                bus.clear = (c == clr_at);
                @(negedge clk);
            end
            bus.clear = 1'b0;
            bus.key_valid = 1'b0;
            repeat (rel) @(negedge clk);
        end
        repeat (8) @(negedge clk);

        // Clear on the accept cycle of key 6.
        do_clear();
        press(4'hA, 8, 8, p);
        press(4'h3, 8, 8, p);
        check("digits_00A3", bus.digits, 16'h00A3);
        tot = 0;
        bus.key_code = 4'h6;
        bus.key_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (bus.new_key === 1'b1) tot++;
        end
        bus.clear = 1'b1;           // high across the accepting edge
        @(negedge clk);
        bus.clear = 1'b0;
        if (bus.new_key === 1'b1) tot++;
        repeat (4) begin
            @(negedge clk);
            if (bus.new_key === 1'b1) tot++;
        end
        check("clear_wins_pulse", tot, 0);
        check("clear_wins_digits", bus.digits, 16'h0000);
        bus.key_valid = 1'b0;
        repeat (8) @(negedge clk);

        // Leading-zero handling with digits 0003.
        press(4'h3, 8, 8, p);
        check("digits_0003", bus.digits, 16'h0003);
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.an == 4'b1110) check("lz_digit0", bus.seg, 7'b0110000);
`ifdef LEADING_ZERO_BLANK_EN
            else check("lz_blank", bus.seg, 7'b1111111);
`else
            else check("lz_zero_shown", bus.seg, 7'b1000000);
`endif
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
